// File: rtl/downsamp_peak_if.sv
// downsamp_peak_if: sample input and valid/ready result bus for the peak decimator.
interface downsamp_peak_if #(parameter int DATA_W = 12);
  logic              ena;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W:0]   dout;
  logic              out_valid;
  logic              out_ready;
  logic              ovf;
  modport master(output ena, data_in, out_ready, input dout, out_valid, ovf);
  modport slave(input ena, data_in, out_ready, output dout, out_valid, ovf);
endinterface

// File: rtl/downsamp_peak.sv
// downsamp_peak: windowed max/min/|x|/peak-to-peak decimator with valid/ready output.
// DOWNSAMP_PEAK_P2P_EN enables the peak-to-peak mode; without it mode 11 acts as max.
module downsamp_peak #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] ratio,
  input  logic [1:0]       mode,
  downsamp_peak_if.slave   bus
);
  logic [CNT_W-1:0]         cnt_q, cnt_d, ratio_q, ratio_d;
  logic [1:0]               mode_q, mode_d, mode_eff, m;
  logic signed [DATA_W-1:0] max_q, max_d, min_q, min_d, x;
  logic [DATA_W:0]          dout_q, dout_d, amax, amin, mag, result;
  logic signed [DATA_W:0]   ext_max, ext_min;
  logic                     valid_q, valid_d, ovf_q, ovf_d, start, last;
  assign mode_eff = start ? mode : mode_q;
`ifdef DOWNSAMP_PEAK_P2P_EN
  assign m = mode_eff;
`else
  assign m = (&mode_eff) ? 2'b00 : mode_eff;
`endif
  always_comb begin
    x       = bus.data_in;
    start   = bus.ena && (clr || cnt_q == '0);
    last    = bus.ena && (start ? ratio <= CNT_W'(1) : cnt_q == ratio_q - 1'b1);
    max_d   = !bus.ena ? max_q : (start || x > max_q) ? x : max_q;
    min_d   = !bus.ena ? min_q : (start || x < min_q) ? x : min_q;
    ext_max = {max_d[DATA_W-1], max_d};
    ext_min = {min_d[DATA_W-1], min_d};
    // extra bit lets the most negative sample's magnitude be represented exactly
    amax    = ext_max[DATA_W] ? -ext_max : ext_max;
    amin    = ext_min[DATA_W] ? -ext_min : ext_min;
    mag     = (amax > amin) ? amax : amin;
    result  = (m == 2'b00) ? ext_max : (m == 2'b01) ? ext_min :
              (m == 2'b10) ? mag : ext_max - ext_min;
    cnt_d   = !bus.ena ? (clr ? '0 : cnt_q) : last ? '0 : start ? CNT_W'(1) : cnt_q + 1'b1;
    ratio_d = start ? ratio : ratio_q;
    mode_d  = start ? mode : mode_q;
    dout_d  = last ? result : dout_q;
    valid_d = last || (valid_q && !bus.out_ready);
    ovf_d   = (ovf_q && !clr) || (last && valid_q && !bus.out_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      ratio_q <= '0;
      mode_q  <= '0;
      max_q   <= '0;
      min_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      mode_q  <= mode_d;
      max_q   <= max_d;
      min_q   <= min_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end
  assign bus.dout      = dout_q;
  assign bus.out_valid = valid_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_downsamp_peak.sv
// tb_downsamp_peak: directed scoreboard bench for downsamp_peak.
module tb_downsamp_peak;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] ratio = '0;
  logic [1:0] mode = '0;
  logic [12:0] sb[$];
  int n_chk = 0;
  int n_bad = 0;
  downsamp_peak_if #(.DATA_W(12)) bus();
  downsamp_peak #(.DATA_W(12), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ratio(ratio), .mode(mode), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_chk++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask
  task automatic smp(input int v, input bit fin = 1'b0, input int want = 0);
    @(negedge clk);
    bus.ena = 1'b1;
    bus.data_in = 12'(v);
    if (fin) sb.push_back(13'(want));
    @(posedge clk);
    #1 bus.ena = 1'b0;
  endtask
  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic got_result(input string tag);
    logic [12:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 16'(bus.out_valid), 16'd1);
      chk({tag, "_dout"}, 16'(bus.dout), 16'(e));
    end
  endtask
  initial begin
    bus.ena = 1'b0;
    bus.data_in = '0;
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dout", 16'(bus.dout), 16'd0);
    chk("rst_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_ovf", 16'(bus.ovf), 16'd0);
    @(negedge clk) rst_n = 1'b1;
    mode = 2'b00; ratio = 8'd10;
    smp(0); smp(5); smp(-3); smp(100); smp(7); smp(-2048); smp(2047); smp(1); smp(2);
    chk("max_early", 16'(bus.out_valid), 16'd0);
    smp(3, 1'b1, 13'h07FF);
    got_result("max10");
    idle(1);
    chk("max_pulse", 16'(bus.out_valid), 16'd0);
    mode = 2'b10; ratio = 8'd4;
    smp(-2048); smp(100); smp(-5); smp(2000, 1'b1, 13'h0800);
    got_result("abs4");
    mode = 2'b01;
    smp(-2048); smp(100); smp(-5); smp(2000, 1'b1, 13'h1800);
    got_result("min4");
    mode = 2'b11; ratio = 8'd3;
    smp(-100); idle(2); smp(50); idle(2);
    chk("p2p_gap", 16'(bus.out_valid), 16'd0);
`ifdef DOWNSAMP_PEAK_P2P_EN
    smp(20, 1'b1, 13'd150);
`else
    smp(20, 1'b1, 13'd50);
`endif
    got_result("p2p3");
    idle(1);
    mode = 2'b00; ratio = 8'd2; bus.out_ready = 1'b0;
    smp(1); smp(2, 1'b1, 13'd2);
    chk("bp_ovf0", 16'(bus.ovf), 16'd0);
    got_result("bp_w1");
    smp(3); smp(4);
    chk("bp_ovf1", 16'(bus.ovf), 16'd1);
    smp(5); smp(6, 1'b1, 13'd6);
    got_result("bp_w3");
    chk("bp_ovf2", 16'(bus.ovf), 16'd1);
    @(negedge clk) clr = 1'b1;
    @(posedge clk) #1 clr = 1'b0;
    chk("clr_ovf", 16'(bus.ovf), 16'd0);
    chk("clr_valid", 16'(bus.out_valid), 16'd1);
    chk("clr_dout", 16'(bus.dout), 16'd6);
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk) #1 bus.out_ready = 1'b0;
    chk("hs_valid", 16'(bus.out_valid), 16'd0);
    bus.out_ready = 1'b1;
    ratio = 8'd5;
    smp(10); smp(20);
    ratio = 8'd2;
    smp(30); smp(40);
    chk("rchg_hold", 16'(bus.out_valid), 16'd0);
    smp(50, 1'b1, 13'd50);
    got_result("rchg5");
    smp(-1);
    chk("rchg_mid", 16'(bus.out_valid), 16'd0);
    smp(-7, 1'b1, 13'h1FFF);
    got_result("rchg2");
    ratio = 8'd0;
    smp(33, 1'b1, 13'd33);
    got_result("r0_a");
    smp(-44, 1'b1, 13'h1FD4);
    got_result("r0_b");
    chk("r0_ovf", 16'(bus.ovf), 16'd0);
    bus.out_ready = 1'b0; ratio = 8'd1;
    smp(77); smp(78);
    chk("pre_rst_ovf", 16'(bus.ovf), 16'd1);
    ratio = 8'd3;
    smp(900);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 16'(bus.out_valid), 16'd0);
    chk("arst_dout", 16'(bus.dout), 16'd0);
    chk("arst_ovf", 16'(bus.ovf), 16'd0);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    smp(5); smp(-3);
    chk("arst_mid", 16'(bus.out_valid), 16'd0);
    smp(4, 1'b1, 13'd5);
    got_result("arst_win");
    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
